// File: rtl/sdram_read_cache.sv
// sdram_read_cache: single-line (16-byte) read cache in front of an SDRAM
// controller. Misses fetch the whole line as an 8-beat wrapping burst,
// critical word first; the requested byte is returned from the first beat.
// Optional feature macro: SDRAM_READ_CACHE_STATS_EN adds saturating
// hit/miss counters on hit_count_o / miss_count_o.
module sdram_read_cache (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        rd_i,
    input  logic [31:0] rd_addr_i,
    input  logic        invalidate_i,
    output logic        ready_o,
    output logic        rd_valid_o,
    output logic [7:0]  rd_data_o,
    output logic        sdram_acc_o,
    output logic [31:0] sdram_adr_o,
    output logic        sdram_we_o,
    output logic [1:0]  sdram_sel_o,
    input  logic        sdram_ack_i,
    input  logic [15:0] sdram_dat_i,
    input  logic [31:0] sdram_adr_i
`ifdef SDRAM_READ_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count_o,
    output logic [15:0] miss_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FILL_REQ,
        FILL_DATA
    } state_t;

    state_t      state_q;
    logic [15:0] line_q [8];
    logic [27:0] tag_q;
    logic        valid_q;
    logic        inv_seen_q;
    logic [31:0] req_addr_q;
    logic [2:0]  beat_q;

    logic        hit;
    logic        accept_hit;
    logic        accept_miss;
    logic        line_we;
    logic [15:0] hit_word;
    logic [7:0]  hit_byte;
    logic [7:0]  crit_byte;

    // Only the word index of the controller address is needed.
    logic        unused_adr_bits;
    assign unused_adr_bits = ^{sdram_adr_i[31:4], sdram_adr_i[0]};

    assign ready_o     = (state_q == IDLE);
    assign sdram_we_o  = 1'b0;
    assign sdram_sel_o = 2'b11;

    // Hit detection and read-side byte selection; a concurrent invalidate
    // kills the hit so the request is handled as a miss.
    always_comb begin
        hit         = valid_q && (tag_q == rd_addr_i[31:4]) && !invalidate_i;
        accept_hit  = (state_q == IDLE) && rd_i && hit;
        accept_miss = (state_q == IDLE) && rd_i && !hit;
        hit_word    = line_q[rd_addr_i[3:1]];
        hit_byte    = rd_addr_i[0] ? hit_word[15:8] : hit_word[7:0];
        crit_byte   = req_addr_q[0] ? sdram_dat_i[15:8] : sdram_dat_i[7:0];
        line_we     = !sdram_rst &&
                      (((state_q == FILL_REQ) && sdram_ack_i) || (state_q == FILL_DATA));
    end

    // Line data storage: one burst word per cycle at the controller's word index.
    always_ff @(posedge sdram_clk) begin
        if (line_we) begin
            line_q[sdram_adr_i[3:1]] <= sdram_dat_i;
        end
    end

    // Control FSM with registered read response and controller request.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            inv_seen_q  <= 1'b0;
            tag_q       <= '0;
            req_addr_q  <= '0;
            beat_q      <= '0;
            sdram_acc_o <= 1'b0;
            sdram_adr_o <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
        end else begin
            rd_valid_o <= 1'b0;
            if (invalidate_i) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept_hit) begin
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= hit_byte;
                    end else if (accept_miss) begin
                        // The old line is overwritten by the burst, so it
                        // stops being valid as soon as the fill starts.
                        req_addr_q  <= rd_addr_i;
                        sdram_adr_o <= {rd_addr_i[31:1], 1'b0};
                        sdram_acc_o <= 1'b1;
                        valid_q     <= 1'b0;
                        inv_seen_q  <= 1'b0;
                        state_q     <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (invalidate_i) begin
                        inv_seen_q <= 1'b1;
                    end
                    if (sdram_ack_i) begin
                        sdram_acc_o <= 1'b0;
                        beat_q      <= 3'd1;
                        rd_valid_o  <= 1'b1;
                        rd_data_o   <= crit_byte;
                        state_q     <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (invalidate_i) begin
                        inv_seen_q <= 1'b1;
                    end
                    beat_q <= beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        tag_q   <= req_addr_q[31:4];
                        valid_q <= !(inv_seen_q || invalidate_i);
                        beat_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SDRAM_READ_CACHE_STATS_EN
    // Saturating counters of accepted hits and misses.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            if (accept_hit && (hit_count_o != 16'hFFFF)) begin
                hit_count_o <= hit_count_o + 16'd1;
            end
            if (accept_miss && (miss_count_o != 16'hFFFF)) begin
                miss_count_o <= miss_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_read_cache.sv
// Testbench for sdram_read_cache: directed scenarios plus randomized reads
// checked against a line-level reference model (valid/tag + memory image).
// Define SDRAM_READ_CACHE_STATS_EN to also exercise the counters.
`timescale 1ns/1ps
module tb_sdram_read_cache;

    logic        sdram_clk;
    logic        sdram_rst;
    logic        rd_i;
    logic [31:0] rd_addr_i;
    logic        invalidate_i;
    logic        ready_o;
    logic        rd_valid_o;
    logic [7:0]  rd_data_o;
    logic        sdram_acc_o;
    logic [31:0] sdram_adr_o;
    logic        sdram_we_o;
    logic [1:0]  sdram_sel_o;
    logic        sdram_ack_i;
    logic [15:0] sdram_dat_i;
    logic [31:0] sdram_adr_i;
`ifdef SDRAM_READ_CACHE_STATS_EN
    logic [15:0] hit_count_o;
    logic [15:0] miss_count_o;
`endif

    sdram_read_cache dut (
        .sdram_clk    (sdram_clk),
        .sdram_rst    (sdram_rst),
        .rd_i         (rd_i),
        .rd_addr_i    (rd_addr_i),
        .invalidate_i (invalidate_i),
        .ready_o      (ready_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .sdram_acc_o  (sdram_acc_o),
        .sdram_adr_o  (sdram_adr_o),
        .sdram_we_o   (sdram_we_o),
        .sdram_sel_o  (sdram_sel_o),
        .sdram_ack_i  (sdram_ack_i),
        .sdram_dat_i  (sdram_dat_i),
        .sdram_adr_i  (sdram_adr_i)
`ifdef SDRAM_READ_CACHE_STATS_EN
        ,
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
`endif
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the cache line should hold, and counts.
    bit          m_valid;
    logic [27:0] m_tag;
    int          m_hits;
    int          m_misses;
    logic [15:0] mem [logic [31:0]];

    function automatic logic [15:0] mem_word(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return wa[15:0] ^ {wa[23:16], wa[31:24]} ^ 16'h5A3C;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [15:0] w;
        w = mem_word({a[31:1], 1'b0});
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [31:0] sat16(input int n);
        return (n > 65535) ? 32'hFFFF : 32'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sdram_rst    = 1'b1;
        rd_i         = 1'b0;
        invalidate_i = 1'b0;
        sdram_ack_i  = 1'b0;
        repeat (2) @(negedge sdram_clk);
        sdram_rst = 1'b0;
        m_valid  = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        check("rst_ready",    32'(ready_o),     32'd1);
        check("rst_rd_valid", 32'(rd_valid_o),  32'd0);
        check("rst_rd_data",  32'(rd_data_o),   32'd0);
        check("rst_acc",      32'(sdram_acc_o), 32'd0);
        check("rst_adr",      sdram_adr_o,      32'd0);
        check("rst_we",       32'(sdram_we_o),  32'd0);
        check("rst_sel",      32'(sdram_sel_o), 32'd3);
`ifdef SDRAM_READ_CACHE_STATS_EN
        check("rst_hit_cnt",  32'(hit_count_o),  32'd0);
        check("rst_miss_cnt", 32'(miss_count_o), 32'd0);
`endif
    endtask

    // One request; a miss is served by a wrapping critical-word-first burst.
    // inv_beat / rst_beat (1..8, 0 = none) inject invalidate / reset on that beat.
    task automatic do_read(input logic [31:0] a, input int inv_beat, input int rst_beat,
                           input bit inv_with_req);
        bit          exp_hit;
        bit          aborted;
        bit          inv_fill;
        logic [7:0]  exp_b;
        logic [31:0] base;
        logic [31:0] wa;
        int          crit;
        int          idx;
        int          d;
        exp_hit = m_valid && (m_tag == a[31:4]) && !inv_with_req;
        exp_b   = mem_byte(a);
        check("ready_before_req", 32'(ready_o), 32'd1);
        rd_i         = 1'b1;
        rd_addr_i    = a;
        invalidate_i = inv_with_req;
        @(negedge sdram_clk);
        rd_i         = 1'b0;
        invalidate_i = 1'b0;
        rd_addr_i    = $urandom;
        if (exp_hit) begin
            m_hits++;
            check("hit_rd_valid", 32'(rd_valid_o),  32'd1);
            check("hit_rd_data",  32'(rd_data_o),   32'(exp_b));
            check("hit_acc",      32'(sdram_acc_o), 32'd0);
            return;
        end
        m_misses++;
        m_valid = 1'b0;
        check("miss_acc",      32'(sdram_acc_o), 32'd1);
        check("miss_adr",      sdram_adr_o,      {a[31:1], 1'b0});
        check("miss_rd_valid", 32'(rd_valid_o),  32'd0);
        check("miss_ready",    32'(ready_o),     32'd0);
        d = $urandom_range(0, 3);
        repeat (d) begin
            @(negedge sdram_clk);
            check("wait_acc", 32'(sdram_acc_o), 32'd1);
            check("wait_adr", sdram_adr_o,      {a[31:1], 1'b0});
        end
        crit     = int'(a[3:1]);
        base     = {a[31:4], 4'b0};
        aborted  = 1'b0;
        inv_fill = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx         = (crit + k - 1) % 8;
            wa          = base + 32'(idx * 2);
            sdram_dat_i = mem_word(wa);
            sdram_adr_i = wa;
            sdram_ack_i = (k == 1) || ($urandom_range(0, 3) == 0);
            if (!aborted) begin
                rd_i      = ($urandom_range(0, 2) == 0);
                rd_addr_i = $urandom;
            end
            if (k == inv_beat) begin
                invalidate_i = 1'b1;
                inv_fill     = 1'b1;
            end
            if (k == rst_beat) begin
                sdram_rst = 1'b1;
                aborted   = 1'b1;
            end
            @(negedge sdram_clk);
            invalidate_i = 1'b0;
            sdram_rst    = 1'b0;
            sdram_ack_i  = 1'b0;
            rd_i         = 1'b0;
            if (k == 1 && !aborted) begin
                check("crit_rd_valid", 32'(rd_valid_o),  32'd1);
                check("crit_rd_data",  32'(rd_data_o),   32'(exp_b));
                check("after_ack_acc", 32'(sdram_acc_o), 32'd0);
            end else begin
                check("no_extra_rd_valid", 32'(rd_valid_o), 32'd0);
            end
            if (aborted) begin
                check("abort_ready", 32'(ready_o),     32'd1);
                check("abort_acc",   32'(sdram_acc_o), 32'd0);
            end else begin
                check("fill_ready", 32'(ready_o), (k == 8) ? 32'd1 : 32'd0);
            end
        end
        if (aborted) begin
            m_valid  = 1'b0;
            m_hits   = 0;
            m_misses = 0;
        end else begin
            m_valid = !inv_fill;
            m_tag   = a[31:4];
        end
    endtask

    task automatic do_invalidate();
        invalidate_i = 1'b1;
        @(negedge sdram_clk);
        invalidate_i = 1'b0;
        m_valid = 1'b0;
        check("inv_ready",    32'(ready_o),    32'd1);
        check("inv_rd_valid", 32'(rd_valid_o), 32'd0);
    endtask

    task automatic stray_ack();
        sdram_ack_i = 1'b1;
        sdram_dat_i = 16'($urandom);
        sdram_adr_i = $urandom;
        @(negedge sdram_clk);
        sdram_ack_i = 1'b0;
        check("stray_ready",    32'(ready_o),     32'd1);
        check("stray_acc",      32'(sdram_acc_o), 32'd0);
        check("stray_rd_valid", 32'(rd_valid_o),  32'd0);
    endtask

    logic [31:0] pool [3];

    initial begin
        sdram_rst    = 1'b1;
        rd_i         = 1'b0;
        rd_addr_i    = '0;
        invalidate_i = 1'b0;
        sdram_ack_i  = 1'b0;
        sdram_dat_i  = '0;
        sdram_adr_i  = '0;
        m_valid      = 1'b0;
        m_tag        = '0;
        m_hits       = 0;
        m_misses     = 0;
        pool[0] = 32'h1000_0000;
        pool[1] = 32'h2000_0040;
        pool[2] = 32'hFFFF_FFF0;

        do_reset();

        // Cold miss at 0x1235, burst from index 2 with 0x1122, 0x2233 ... 0x8899.
        for (int k = 0; k < 8; k++)
            mem[32'h1230 + 32'(((2 + k) % 8) * 2)] = 16'(16'h1122 + 16'h1111 * k);
        do_read(32'h0000_1235, 0, 0, 1'b0);
        // Hit at 0x123C: low byte of word index 6.
        do_read(32'h0000_123C, 0, 0, 1'b0);

        // Wrap: fill starting at index 7, then read all 16 bytes as hits.
        do_read(32'h000A_BCDE, 0, 0, 1'b0);
        for (int b = 0; b < 16; b++)
            do_read(32'h000A_BCD0 + 32'(b), 0, 0, 1'b0);

        // Invalidate on beat 4: critical byte still returned, line left invalid.
        do_read(32'h0005_5502, 4, 0, 1'b0);
        do_read(32'h0005_5509, 0, 0, 1'b0);
        do_read(32'h0005_550F, 0, 0, 1'b0);

        // Reset on beat 3: fill abandoned, same line misses afterwards.
        do_read(32'h0007_7770, 0, 3, 1'b0);
        do_read(32'h0007_7771, 0, 0, 1'b0);
        do_read(32'h0007_7774, 0, 0, 1'b0);

        // Read together with invalidate on a resident line is a miss.
        do_read(32'h0007_7776, 0, 0, 1'b1);
        do_invalidate();
        do_read(32'h0007_7777, 0, 0, 1'b0);
        stray_ack();

        // Randomized mix over a few lines.
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                do_invalidate();
            end else if (sel == 1) begin
                stray_ack();
            end else begin
                logic [31:0] a;
                a = pool[$urandom_range(0, 2)] + 32'($urandom_range(0, 15));
                do_read(a, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0, 0,
                        ($urandom_range(0, 9) == 0));
            end
        end

`ifdef SDRAM_READ_CACHE_STATS_EN
        check("rand_hit_cnt",  32'(hit_count_o),  sat16(m_hits));
        check("rand_miss_cnt", 32'(miss_count_o), sat16(m_misses));
        do_reset();
        do_read(32'h0000_4000, 0, 0, 1'b0);
        do_read(32'h0000_5000, 0, 0, 1'b0);
        do_read(32'h0000_6000, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++)
            do_read(32'h0000_6000 + 32'(i), 0, 0, 1'b0);
        check("stats_hit_cnt",  32'(hit_count_o),  sat16(m_hits));
        check("stats_miss_cnt", 32'(miss_count_o), sat16(m_misses));
        rd_i      = 1'b1;
        rd_addr_i = 32'h0000_600A;
        repeat (70000) @(negedge sdram_clk);
        rd_i   = 1'b0;
        m_hits = m_hits + 70000;
        check("sat_rd_valid",  32'(rd_valid_o),   32'd1);
        check("sat_hit_cnt",   32'(hit_count_o),  sat16(m_hits));
        check("sat_miss_cnt",  32'(miss_count_o), sat16(m_misses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_read_cache.md
SDRAM_READ_CACHE -- requirements
Module: sdram_read_cache

Interface
REQ-001 The block SHALL have a single clock, sdram_clk; reset is synchronous and active-high on sdram_rst.
REQ-002 The block SHALL have these ports:
- sdram_clk  in  1  clock
- sdram_rst  in  1  synchronous active-high reset
- rd_i  in  1  byte read request, sampled only while ready_o=1
- rd_addr_i  in  32  byte address of the request
- invalidate_i  in  1  clear the line-valid bit
- ready_o  out  1  block can accept rd_i
- rd_valid_o  out  1  one-cycle pulse: rd_data_o is valid
- rd_data_o  out  8  returned byte
- sdram_acc_o  out  1  access request to the SDRAM controller
- sdram_adr_o  out  32  controller byte address
- sdram_we_o  out  1  tied 0
- sdram_sel_o  out  2  tied 2'b11
- sdram_ack_i  in  1  controller read ack; first burst word valid this cycle
- sdram_dat_i  in  16  controller read data, one word per cycle for 8 cycles from ack
- sdram_adr_i  in  32  controller address of the current sdram_dat_i word
- hit_count_o  out  16  present only with SDRAM_READ_CACHE_STATS_EN
- miss_count_o  out  16  present only with SDRAM_READ_CACHE_STATS_EN

Function
REQ-003 The block SHALL hold one 16-byte line: 8 x 16-bit words, a 28-bit tag equal to addr[31:4], and a valid bit.
REQ-004 Byte select SHALL be addr[0]=0 -> word[7:0] and addr[0]=1 -> word[15:8]; the word index is addr[3:1].
REQ-005 The states SHALL be IDLE, FILL_REQ and FILL_DATA; ready_o SHALL be 1 only in IDLE.
REQ-006 Hit handling: rd_i in IDLE with valid=1 and tag==rd_addr_i[31:4] SHALL produce rd_valid_o=1 with the byte on the next cycle; the block stays in IDLE.
REQ-007 Miss handling: rd_i in IDLE without a hit SHALL latch the address and move to FILL_REQ.
REQ-008 The sdram_acc_o drive is registered: sdram_acc_o=1 with sdram_adr_o={addr[31:1],1'b0} from the cycle after the miss until the cycle after sdram_ack_i is seen.
REQ-009 sdram_adr_o SHALL stay stable while sdram_acc_o=1.
REQ-010 On the sdram_ack_i cycle the block SHALL write sdram_dat_i into word sdram_adr_i[3:1] and enter FILL_DATA with beat count 1.
REQ-011 In FILL_DATA the block SHALL write one word per cycle at sdram_adr_i[3:1], which wraps mod 8, until 8 beats total are stored.
REQ-012 Critical word first: the first burst word is the requested word, so rd_valid_o SHALL pulse on the cycle after sdram_ack_i with the requested byte.
REQ-013 On the 8th beat the block SHALL set tag=addr[31:4] and valid=1, unless an invalidate occurred during the fill, and return to IDLE on the next cycle.
REQ-014 invalidate_i SHALL clear valid on the next cycle in any state.
REQ-015 invalidate_i asserted during FILL_REQ or FILL_DATA SHALL complete the burst, still deliver the critical byte, and leave valid=0.
REQ-016 When rd_i and invalidate_i are both asserted in IDLE, invalidate SHALL win and the request SHALL be treated as a miss.
REQ-017 rd_i while ready_o=0 SHALL be ignored, and rd_valid_o SHALL never pulse twice for one request.
REQ-018 Stray behaviour: sdram_ack_i outside FILL_REQ SHALL be ignored.

Reset
REQ-019 On sdram_rst the block SHALL set state=IDLE, valid=0, sdram_acc_o=0, rd_valid_o=0, rd_data_o=0, sdram_adr_o=0 and beat count=0; with STATS_EN it SHALL also set both counters to 0.
REQ-020 Reset asserted mid-fill SHALL abandon the fill: no rd_valid_o, line invalid, and any remaining controller beats ignored.
REQ-021 The output ready_o SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-022 With SDRAM_READ_CACHE_STATS_EN defined, the block SHALL provide hit_count_o and miss_count_o.
- Each counter increments by 1 per accepted hit or miss respectively.
- Each saturates at 16'hFFFF.
REQ-023 Without SDRAM_READ_CACHE_STATS_EN, the block SHALL omit both ports and the counter logic, and its behaviour SHALL otherwise be identical.

Verification
REQ-024 Cold miss: reset, then rd_i at 0x00001235, controller returns words 0x1122..0x8899 starting at index 2.
- sdram_acc_o=1 with sdram_adr_o=0x00001234.
- rd_valid_o 1 cycle after ack with rd_data_o=0x11 (high byte of 0x1122).
- ready_o=1 8 cycles after ack.
REQ-025 Hit: after the fill above, rd_i at 0x0000123C -> rd_valid_o next cycle with the low byte of the word stored at index 6, and sdram_acc_o stays 0.
REQ-026 Wrap: a fill started at index 7 -> words stored at indices 7,0,1,...,6, and all 16 bytes read back correctly as hits.
REQ-027 Invalidate mid-fill: invalidate_i pulsed on beat 4 -> critical byte still returned, and the next rd_i to the same line misses (new sdram_acc_o).
REQ-028 Reset mid-fill: sdram_rst on beat 3 -> no rd_valid_o, ready_o=1 after reset, and a subsequent rd_i to the same line misses.
REQ-029 With STATS_EN: 3 misses and 5 hits -> miss_count_o=3, hit_count_o=5; 70000 hits -> hit_count_o=0xFFFF.
